// File: rtl/fft16_pkg.sv
// Shared types and constants for the 16-point FFT datapath.
// A complex sample travels as one CW-bit word, {re, im}, with each part in signed Q1.15.
package fft16_pkg;

  localparam int DW       = 16;
  localparam int CW       = 2 * DW;
  localparam int SCALE_SH = 2;

  localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  function automatic logic [CW-1:0] pack_cplx(input cplx_t c);
    return {c.re, c.im};
  endfunction

  function automatic cplx_t unpack_cplx(input logic [CW-1:0] w);
    cplx_t c;
    c.re = w[CW-1:DW];
    c.im = w[DW-1:0];
    return c;
  endfunction

endpackage

// File: rtl/radix4_bf_stage2_if.sv
// Bus between commutStage2 and the final radix-4 butterfly.
// It carries four input lanes, four output lanes and the frame position and overflow status.
interface radix4_bf_stage2_if;
  import fft16_pkg::*;

  logic          in_valid;
  logic [CW-1:0] data_in_0;
  logic [CW-1:0] data_in_1;
  logic [CW-1:0] data_in_2;
  logic [CW-1:0] data_in_3;
  logic          out_valid;
  logic [CW-1:0] output_0;
  logic [CW-1:0] output_1;
  logic [CW-1:0] output_2;
  logic [CW-1:0] output_3;
  logic [1:0]    out_idx;
  logic          out_last;
  logic          ovf_sticky;

  modport master (
    output in_valid, data_in_0, data_in_1, data_in_2, data_in_3,
    input  out_valid, output_0, output_1, output_2, output_3,
           out_idx, out_last, ovf_sticky
  );

  modport slave (
    input  in_valid, data_in_0, data_in_1, data_in_2, data_in_3,
    output out_valid, output_0, output_1, output_2, output_3,
           out_idx, out_last, ovf_sticky
  );

endinterface

// File: rtl/cplx_scale_sat.sv
// Scales one butterfly component from DW+2 bits down to DW bits.
// The value is divided by 4 and then saturated to the DW-bit range.
// With BF_ROUND_EN defined, 2 is added before the shift, which rounds half up.
// Otherwise the shift truncates toward -inf. That path can never exceed the range, so ovf stays low.
module cplx_scale_sat
  import fft16_pkg::*;
(
  input  logic signed [DW+1:0] din,
  output logic signed [DW-1:0] dout,
  output logic                 ovf
);

  // One guard bit so the rounding add cannot wrap.
  localparam int W = DW + 3;
  localparam logic signed [W-1:0] HI  = W'(SAT_MAX);
  localparam logic signed [W-1:0] LO  = W'(SAT_MIN);
  localparam logic signed [W-1:0] RND = W'(1 << (SCALE_SH - 1));

  logic signed [W-1:0] scaled;

  function automatic logic signed [W-1:0] scale(input logic signed [DW+1:0] x);
    logic signed [W-1:0] t;
    t = {x[DW+1], x};
`ifdef BF_ROUND_EN
    t = t + RND;
`endif
    return t >>> SCALE_SH;
  endfunction

  function automatic logic is_ovf(input logic signed [W-1:0] v);
    return (v > HI) || (v < LO);
  endfunction

  function automatic logic signed [DW-1:0] saturate(input logic signed [W-1:0] v);
    if (v > HI) return SAT_MAX;
    if (v < LO) return SAT_MIN;
    return v[DW-1:0];
  endfunction

  // Combinational shift/round followed by the clamp.
  always_comb begin
    scaled = scale(din);
    dout   = saturate(scaled);
    ovf    = is_ovf(scaled);
  end

endmodule

// File: rtl/radix4_bf_stage2.sv
// Final radix-4 butterfly of the 16-point FFT.
// P1 registers the partial sums a+-c and b+-d. P2 forms X0..X3, scales by 1/4 and saturates.
// It then registers the group together with its index within the frame.
// Optional rounding is enabled with the macro BF_ROUND_EN.
module radix4_bf_stage2
  import fft16_pkg::*;
#(
  parameter int GROUPS = 4
) (
  input  logic              clk,
  input  logic              reset,
  radix4_bf_stage2_if.slave bus
);

  localparam logic [1:0] LAST = 2'(GROUPS - 1);

  cplx_t a, b, c, d;
  assign a = unpack_cplx(bus.data_in_0);
  assign b = unpack_cplx(bus.data_in_1);
  assign c = unpack_cplx(bus.data_in_2);
  assign d = unpack_cplx(bus.data_in_3);

  function automatic logic signed [DW:0] ext1(input logic signed [DW-1:0] v);
    return {v[DW-1], v};
  endfunction

  function automatic logic signed [DW+1:0] ext2(input logic signed [DW:0] v);
    return {v[DW], v};
  endfunction

  logic                vld_p1;
  logic signed [DW:0]  s_re_p1 [4];
  logic signed [DW:0]  s_im_p1 [4];

  // P1: s0=a+c, s1=a-c, s2=b+d, s3=b-d, captured only on valid beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        s_re_p1[k] <= '0;
        s_im_p1[k] <= '0;
      end
    end else begin
      vld_p1 <= bus.in_valid;
      if (bus.in_valid) begin
        s_re_p1[0] <= ext1(a.re) + ext1(c.re);
        s_im_p1[0] <= ext1(a.im) + ext1(c.im);
        s_re_p1[1] <= ext1(a.re) - ext1(c.re);
        s_im_p1[1] <= ext1(a.im) - ext1(c.im);
        s_re_p1[2] <= ext1(b.re) + ext1(d.re);
        s_im_p1[2] <= ext1(b.im) + ext1(d.im);
        s_re_p1[3] <= ext1(b.re) - ext1(d.re);
        s_im_p1[3] <= ext1(b.im) - ext1(d.im);
      end
    end
  end

  logic signed [DW+1:0] x_re [4];
  logic signed [DW+1:0] x_im [4];

  // Combine the partial sums. Multiplying by -j maps (r, i) to (i, -r), and by +j to (-i, r).
  always_comb begin
    x_re[0] = ext2(s_re_p1[0]) + ext2(s_re_p1[2]);
    x_im[0] = ext2(s_im_p1[0]) + ext2(s_im_p1[2]);
    x_re[1] = ext2(s_re_p1[1]) + ext2(s_im_p1[3]);
    x_im[1] = ext2(s_im_p1[1]) - ext2(s_re_p1[3]);
    x_re[2] = ext2(s_re_p1[0]) - ext2(s_re_p1[2]);
    x_im[2] = ext2(s_im_p1[0]) - ext2(s_im_p1[2]);
    x_re[3] = ext2(s_re_p1[1]) - ext2(s_im_p1[3]);
    x_im[3] = ext2(s_im_p1[1]) + ext2(s_re_p1[3]);
  end

  logic signed [DW-1:0] y_re [4];
  logic signed [DW-1:0] y_im [4];
  logic [3:0]           ovf_re, ovf_im;

  for (genvar k = 0; k < 4; k++) begin : g_sat
    cplx_scale_sat u_re (.din(x_re[k]), .dout(y_re[k]), .ovf(ovf_re[k]));
    cplx_scale_sat u_im (.din(x_im[k]), .dout(y_im[k]), .ovf(ovf_im[k]));
  end

  logic       vld_p2;
  cplx_t      y_p2 [4];
  logic [1:0] idx_p2;
  logic [1:0] grp_cnt;
  logic       ovf_p2;

  // P2: register the scaled outputs. Data and index hold through bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2  <= 1'b0;
      idx_p2  <= '0;
      grp_cnt <= '0;
      ovf_p2  <= 1'b0;
      for (int k = 0; k < 4; k++) y_p2[k] <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        for (int k = 0; k < 4; k++) begin
          y_p2[k].re <= y_re[k];
          y_p2[k].im <= y_im[k];
        end
        idx_p2  <= grp_cnt;
        grp_cnt <= (grp_cnt == LAST) ? 2'd0 : grp_cnt + 2'd1;
        if (|{ovf_re, ovf_im}) ovf_p2 <= 1'b1;
      end
    end
  end

  assign bus.out_valid  = vld_p2;
  assign bus.output_0   = pack_cplx(y_p2[0]);
  assign bus.output_1   = pack_cplx(y_p2[1]);
  assign bus.output_2   = pack_cplx(y_p2[2]);
  assign bus.output_3   = pack_cplx(y_p2[3]);
  assign bus.out_idx    = idx_p2;
  assign bus.out_last   = vld_p2 && (idx_p2 == LAST);
  assign bus.ovf_sticky = ovf_p2;

endmodule

// File: doc/radix4_bf_stage2.md
Name: radix4_bf_stage2

Overview:
- Final radix-4 butterfly of the 16-point FFT. It sits directly downstream of commutStage2 and consumes its four 32-bit lanes.
- Each valid input beat is one 4-point group (a,b,c,d). The block computes the four radix-4 outputs, scales them by 1/4, saturates, and emits them two cycles later.
- A group index and a frame-last flag let the output/reorder logic locate each of the four groups in a frame.

Parameters:
- DW, 16, width of each real/imag component (signed two's complement, Q1.15).
- GROUPS, 4, groups per frame (16 points / radix 4); out_idx wraps at GROUPS-1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  data_in_0..3 carry a valid group this cycle.
- data_in_0  in  2*DW  lane a, {re[31:16], im[15:0]}.
- data_in_1  in  2*DW  lane b, same packing.
- data_in_2  in  2*DW  lane c, same packing.
- data_in_3  in  2*DW  lane d, same packing.
- out_valid  out  1  output_0..3 valid.
- output_0  out  2*DW  X0, same packing.
- output_1  out  2*DW  X1, same packing.
- output_2  out  2*DW  X2, same packing.
- output_3  out  2*DW  X3, same packing.
- out_idx  out  2  group index within frame, 0..3.
- out_last  out  1  high with out_valid when out_idx==3.
- ovf_sticky  out  1  set when any saturation has occurred since reset.

Behaviour:
- Reset (synchronous, active-high; sampled on clk rising edge) clears all outputs and all pipeline/valid registers to 0, out_idx to 0 and ovf_sticky to 0. Asserting reset mid-frame discards in-flight groups, and the next accepted group is idx 0.
- Math:
  - X0 = a+b+c+d
  - X1 = a - j·b - c + j·d
  - X2 = a-b+c-d
  - X3 = a + j·b - c - j·d
  - -j·(br + j·bi) = bi - j·br; +j·(br + j·bi) = -bi + j·br.
- Pipeline stage P1, registered on in_valid:
  - s0 = a+c, s1 = a-c, s2 = b+d, s3 = b-d.
  - Per component, width DW+1 (sign-extended, no loss).
- Pipeline stage P2, registered:
  - X0 = s0+s2, X2 = s0-s2.
  - X1 = s1 + (-j)·s3, X3 = s1 + j·s3.
  - Width DW+2, then scale.
- Scaling: arithmetic shift right by 2 (truncation toward -inf), then saturate to [-2^(DW-1), 2^(DW-1)-1] per component.
- Latency: exactly 2 cycles from in_valid to out_valid. Throughput is 1 group/cycle; no backpressure.
- Bubbles: when in_valid=0, P1 valid clears and output data registers hold their last values. out_valid=0 and out_idx holds.
- out_idx increments by 1 on each out_valid cycle and wraps 3→0. out_last = out_valid && out_idx==3.
- ovf_sticky is set in the cycle any component saturates and clears only on reset. In truncation mode the worst case (131070>>2 = 32767) never saturates, so saturation is reachable only with rounding enabled.
- Reset asserted on the same edge as in_valid: reset wins and the group is dropped.

Optional Feature:
- Macro: BF_ROUND_EN.
- Defined: add 2 (round half up) before the >>2, then saturate.
- Undefined: plain truncating >>2; saturation logic is still present but ovf_sticky stays 0 for all inputs.

Decomposition:
- Package fft16_pkg holds:
  - DW, CW=2*DW, SCALE_SH=2.
  - Typedef cplx_t {logic signed [DW-1:0] re, im}.
  - Function pack/unpack between cplx_t and the 32-bit word.
  - Constants SAT_MAX/SAT_MIN.
- One sub-module: cplx_scale_sat (DW+2 in → DW out, shift/round/saturate, overflow flag), instantiated once per output component (8×).

Test Plan:
- Reset, then in_valid=1 for 1 cycle, a=b=c=d=0x1000_0000 → 2 cycles later out_valid=1, output_0=0x1000_0000, output_1..3=0, out_idx=0.
- a=0x4000_0000 only (b=c=d=0) → output_0..3 all 0x1000_0000.
- b=0x4000_0000 only → output_0=0x1000_0000, output_1=0x0000_F000 (-j·4096), output_2=0xF000_0000, output_3=0x0000_1000.
- Four consecutive groups with a 2-cycle bubble after group 1 → out_idx 0,1,(hold),2,3; out_last high only on idx 3; fifth group idx 0.
- BF_ROUND_EN, a=0x7FFF_0000, b=0x0000_7FFF, c=0x8000_0000, d=0x0000_8000 → output_1 re=0x7FFF (saturated), ovf_sticky=1. Same stimulus without the macro → re=0x7FFF, ovf_sticky=0.
- Reset asserted while groups 1–2 are in the pipeline → no out_valid for those groups; the next group emerges with out_idx=0, and ovf_sticky is cleared.
